rename_unit: RTL and testbench

- Parametrised, clocked register-rename stage between decode and dispatch.
- Maps architectural source/destination registers to physical registers via a speculative RAT, a circular free list and a per-physical-register ready table.
- Allocates ROB tags, frees physical registers on in-order commit, and recovers on flush from a committed RAT.
- One instruction per cycle; registered output with a valid/ready handshake.

---
 rtl/rename_unit.sv | 201 ++++++++++++++++++++
 tb/tb_rename_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Register-rename stage between decode and dispatch: speculative RAT, circular
// free list and ready table, with a committed RAT and free-list head for flush recovery.
module rename_unit #(
    parameter  int ARCH_REGS = 32,
    parameter  int PHYS_REGS = 64,
    parameter  int ROB_DEPTH = 64,
    localparam int AREG_W    = $clog2(ARCH_REGS),
    localparam int PREG_W    = $clog2(PHYS_REGS),
    localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_sr1,
    input  logic [AREG_W-1:0] in_sr2,
    input  logic [AREG_W-1:0] in_dr,
    input  logic              in_dr_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_sr1_p,
    output logic [PREG_W-1:0] out_sr2_p,
    output logic [PREG_W-1:0] out_dr_p,
    output logic [PREG_W-1:0] out_old_dr_p,
    output logic              out_s1_ready,
    output logic              out_s2_ready,
    output logic [ROB_W-1:0]  out_rob_num,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_p,
    input  logic              commit_valid,
    input  logic              commit_dr_wen,
    input  logic [AREG_W-1:0] commit_dr,
    input  logic [PREG_W-1:0] commit_p,
    input  logic [PREG_W-1:0] commit_old_p,
    input  logic              flush
);

    // One spare slot keeps tail - head unambiguous when the list is full.
    localparam int FL_CAP   = PHYS_REGS - ARCH_REGS;
    localparam int FL_DEPTH = FL_CAP + 1;
    localparam int FL_W     = $clog2(FL_DEPTH + 1);

    typedef logic [FL_W-1:0]   fl_ptr_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [ROB_W-1:0]  rob_t;

    preg_t                rat       [ARCH_REGS];
    preg_t                crat      [ARCH_REGS];
    preg_t                free_list [FL_DEPTH];
    logic [PHYS_REGS-1:0] ready_q;

    fl_ptr_t head_q, commit_head_q, tail_q, count_q;
    fl_ptr_t head_n, commit_head_n, tail_n, count_n;
    rob_t    rob_cnt_q, commit_cnt_q, commit_cnt_n;
    logic    started_q;

    logic  fire, alloc, commit_push;
    preg_t alloc_p, sr1_p, sr2_p;
    logic  s1_ready, s2_ready;

    function automatic fl_ptr_t fl_inc(input fl_ptr_t p);
        return (p == fl_ptr_t'(FL_DEPTH - 1)) ? '0 : p + fl_ptr_t'(1);
    endfunction

    function automatic fl_ptr_t fl_dist(input fl_ptr_t t, input fl_ptr_t h);
        return (t >= h) ? t - h : t + fl_ptr_t'(FL_DEPTH) - h;
    endfunction

    function automatic rob_t rob_inc(input rob_t c);
        return (c == rob_t'(ROB_DEPTH - 1)) ? '0 : c + rob_t'(1);
    endfunction

    // Start-of-cycle count only: a same-cycle commit cannot unblock rename.
    assign in_ready    = started_q && !flush && (!out_valid || out_ready) && (count_q != '0);
    assign fire        = in_valid && in_ready;
    assign alloc       = fire && in_dr_wen && (in_dr != '0);
    assign commit_push = commit_valid && commit_dr_wen && (commit_dr != '0);
    assign alloc_p     = free_list[head_q];

    assign sr1_p    = rat[in_sr1];
    assign sr2_p    = rat[in_sr2];
    assign s1_ready = (in_sr1 == '0) || ready_q[sr1_p] || (wb_valid && (wb_p == sr1_p));
    assign s2_ready = (in_sr2 == '0) || ready_q[sr2_p] || (wb_valid && (wb_p == sr2_p));

    assign commit_cnt_n = commit_valid ? rob_inc(commit_cnt_q) : commit_cnt_q;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        tail_n        = tail_q;
        commit_head_n = commit_head_q;
        head_n        = head_q;
        count_n       = count_q;
        if (commit_push) begin
            tail_n        = fl_inc(tail_q);
            commit_head_n = fl_inc(commit_head_q);
        end
        if (flush) begin
            head_n  = commit_head_n;
            count_n = fl_dist(tail_n, commit_head_n);
        end else begin
            if (alloc) head_n = fl_inc(head_q);
            case ({commit_push, alloc})
                2'b10:   count_n = count_q + fl_ptr_t'(1);
                2'b01:   count_n = count_q - fl_ptr_t'(1);
                default: count_n = count_q;
            endcase
        end
    end

    // NOTE: the mapping tables are reset explicitly; recovery relies on the identity map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= preg_t'(i);
                crat[i] <= preg_t'(i);
            end
        end else begin
            if (commit_push) crat[commit_dr] <= commit_p;
            if (flush) begin
                for (int i = 0; i < ARCH_REGS; i++) begin
                    rat[i] <= (commit_push && (commit_dr == AREG_W'(i))) ? commit_p : crat[i];
                end
            end else if (alloc) begin
                rat[in_dr] <= alloc_p;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                free_list[i] <= (i < FL_CAP) ? preg_t'(ARCH_REGS + i) : '0;
            end
        end else if (commit_push) begin
            free_list[tail_q] <= commit_old_p;
        end
    end

    // A writeback and an allocation of the same register cannot coincide; the clear is written last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= '1;
        end else if (flush) begin
            ready_q <= '1;
        end else begin
            if (wb_valid) ready_q[wb_p]    <= 1'b1;
            if (alloc)    ready_q[alloc_p] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= fl_ptr_t'(FL_CAP);
            count_q       <= fl_ptr_t'(FL_CAP);
            rob_cnt_q     <= '0;
            commit_cnt_q  <= '0;
            started_q     <= 1'b0;
        end else begin
            head_q        <= head_n;
            commit_head_q <= commit_head_n;
            tail_q        <= tail_n;
            count_q       <= count_n;
            commit_cnt_q  <= commit_cnt_n;
            started_q     <= 1'b1;
            if (flush)     rob_cnt_q <= commit_cnt_n;
            else if (fire) rob_cnt_q <= rob_inc(rob_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_sr1_p    <= '0;
            out_sr2_p    <= '0;
            out_dr_p     <= '0;
            out_old_dr_p <= '0;
            out_s1_ready <= 1'b0;
            out_s2_ready <= 1'b0;
            out_rob_num  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid    <= 1'b1;
            out_sr1_p    <= sr1_p;
            out_sr2_p    <= sr2_p;
            out_dr_p     <= alloc ? alloc_p : '0;
            out_old_dr_p <= alloc ? rat[in_dr] : '0;
            out_s1_ready <= s1_ready;
            out_s2_ready <= s2_ready;
            out_rob_num  <= rob_cnt_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    free_list_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(commit_push && !alloc && (count_q == fl_ptr_t'(FL_CAP))));

endmodule

// File: tb/tb_rename_unit.sv
// Randomised scoreboard bench for rename_unit; the bench also plays the ROB,
// committing renamed instructions in order and issuing writebacks.
module tb_rename_unit;

    localparam int ARCH_REGS = 32;
    localparam int PHYS_REGS = 64;
    localparam int ROB_DEPTH = 64;
    localparam int AREG_W    = 5;
    localparam int PREG_W    = 6;
    localparam int ROB_W     = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid, in_ready, in_dr_wen;
    logic [AREG_W-1:0] in_sr1, in_sr2, in_dr;
    logic              out_valid, out_ready, out_s1_ready, out_s2_ready;
    logic [PREG_W-1:0] out_sr1_p, out_sr2_p, out_dr_p, out_old_dr_p;
    logic [ROB_W-1:0]  out_rob_num;
    logic              wb_valid;
    logic [PREG_W-1:0] wb_p;
    logic              commit_valid, commit_dr_wen;
    logic [AREG_W-1:0] commit_dr;
    logic [PREG_W-1:0] commit_p, commit_old_p;
    logic              flush;

    always #5 clk = ~clk;

    rename_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .ROB_DEPTH(ROB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_dr_wen(in_dr_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sr1_p(out_sr1_p), .out_sr2_p(out_sr2_p),
        .out_dr_p(out_dr_p), .out_old_dr_p(out_old_dr_p),
        .out_s1_ready(out_s1_ready), .out_s2_ready(out_s2_ready),
        .out_rob_num(out_rob_num),
        .wb_valid(wb_valid), .wb_p(wb_p),
        .commit_valid(commit_valid), .commit_dr_wen(commit_dr_wen),
        .commit_dr(commit_dr), .commit_p(commit_p), .commit_old_p(commit_old_p),
        .flush(flush)
    );

    typedef struct {
        int sr1_p; int sr2_p; int dr_p; int old_p;
        bit s1r;   bit s2r;   int rob;
    } exp_t;

    typedef struct { bit wen; int dr; int p; int old_p; } rob_ent_t;

    exp_t     exp_q[$];
    rob_ent_t rob_q[$];
    int       m_rat [ARCH_REGS];
    int       m_crat[ARCH_REGS];
    int       m_fl[$];
    int       m_cfl[$];
    bit       m_ready[PHYS_REGS];
    int       m_rob_cnt, m_commit_cnt;
    bit       m_ov, m_started;
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ARCH_REGS; i++) begin
            m_rat[i]  = i;
            m_crat[i] = i;
        end
        m_fl.delete();
        m_cfl.delete();
        for (int i = ARCH_REGS; i < PHYS_REGS; i++) begin
            m_fl.push_back(i);
            m_cfl.push_back(i);
        end
        for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = 1'b1;
        m_rob_cnt = 0;
        m_commit_cnt = 0;
        m_ov = 1'b0;
        m_started = 1'b0;
        exp_q.delete();
        rob_q.delete();
    endtask

    function automatic bit m_in_ready();
        return m_started && !flush && (!m_ov || out_ready) && (m_fl.size() != 0);
    endfunction

    // Reference model: free lists as queues, maps as arrays, applied once per edge.
    exp_t     m_e;
    rob_ent_t m_r;
    bit       m_fire, m_alloc, m_handoff;
    int       m_dummy;
    always @(posedge clk) begin
        if (rst_n) begin
            m_fire    = in_valid && m_in_ready();
            m_handoff = m_ov && out_ready;
            m_alloc   = 1'b0;
            if (m_fire) begin
                m_e.sr1_p = m_rat[in_sr1];
                m_e.sr2_p = m_rat[in_sr2];
                m_e.s1r = (in_sr1 == 0) || m_ready[m_e.sr1_p] || (wb_valid && wb_p == m_e.sr1_p);
                m_e.s2r = (in_sr2 == 0) || m_ready[m_e.sr2_p] || (wb_valid && wb_p == m_e.sr2_p);
                m_alloc = in_dr_wen && (in_dr != 0);
                m_e.dr_p = 0;
                m_e.old_p = 0;
                if (m_alloc) begin
                    m_e.dr_p  = m_fl.pop_front();
                    m_e.old_p = m_rat[in_dr];
                    m_rat[in_dr] = m_e.dr_p;
                end
                m_e.rob = m_rob_cnt;
                m_rob_cnt = (m_rob_cnt + 1) % ROB_DEPTH;
                exp_q.push_back(m_e);
                m_r.wen = in_dr_wen;
                m_r.dr = in_dr;
                m_r.p = m_e.dr_p;
                m_r.old_p = m_e.old_p;
                rob_q.push_back(m_r);
            end
            if (wb_valid) m_ready[wb_p] = 1'b1;
            if (m_alloc)  m_ready[m_e.dr_p] = 1'b0;
            if (commit_valid) begin
                m_commit_cnt = (m_commit_cnt + 1) % ROB_DEPTH;
                if (rob_q.size() > 0) m_r = rob_q.pop_front();
                if (commit_dr_wen && commit_dr != 0) begin
                    m_crat[commit_dr] = commit_p;
                    m_fl.push_back(commit_old_p);
                    m_dummy = m_cfl.pop_front();
                    m_cfl.push_back(commit_old_p);
                end
            end
            if (flush) begin
                if (m_ov && !m_handoff) m_e = exp_q.pop_back();
                m_rat = m_crat;
                m_fl = m_cfl;
                for (int i = 0; i < PHYS_REGS; i++) m_ready[i] = 1'b1;
                m_rob_cnt = m_commit_cnt;
                m_ov = 1'b0;
                rob_q.delete();
            end else if (m_fire) begin
                m_ov = 1'b1;
            end else if (m_handoff) begin
                m_ov = 1'b0;
            end
            m_started = 1'b1;
        end
    end

    // Monitor: compares the handshake and every handed-off instruction.
    exp_t got;
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, m_in_ready());
            check("out_valid", out_valid, m_ov);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got handoff rob=%0d, expected none", out_rob_num);
                end else begin
                    got = exp_q.pop_front();
                    check("out_sr1_p", out_sr1_p, got.sr1_p);
                    check("out_sr2_p", out_sr2_p, got.sr2_p);
                    check("out_dr_p", out_dr_p, got.dr_p);
                    check("out_old_dr_p", out_old_dr_p, got.old_p);
                    check("out_s1_ready", out_s1_ready, got.s1r);
                    check("out_s2_ready", out_s2_ready, got.s2r);
                    check("out_rob_num", out_rob_num, got.rob);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_sr1 = '0; in_sr2 = '0; in_dr = '0; in_dr_wen = 0;
        out_ready = 1; wb_valid = 0; wb_p = '0; flush = 0;
        commit_valid = 0; commit_dr_wen = 0; commit_dr = '0; commit_p = '0; commit_old_p = '0;
    endtask

    // Commit the oldest instruction that has already left the output register.
    task automatic set_commit(input bit en);
        commit_valid = 0; commit_dr_wen = 0; commit_dr = '0; commit_p = '0; commit_old_p = '0;
        if (en && (rob_q.size() >= 2 || (rob_q.size() == 1 && !m_ov))) begin
            commit_valid  = 1;
            commit_dr_wen = rob_q[0].wen;
            commit_dr     = AREG_W'(rob_q[0].dr);
            commit_p      = PREG_W'(rob_q[0].p);
            commit_old_p  = PREG_W'(rob_q[0].old_p);
        end
    endtask

    task automatic drive(input bit v, input int s1, input int s2, input int d, input bit wen,
                         input bit ordy, input bit wbv, input int wbp, input bit cmt, input bit fl);
        in_valid = v; in_sr1 = AREG_W'(s1); in_sr2 = AREG_W'(s2); in_dr = AREG_W'(d);
        in_dr_wen = wen; out_ready = ordy; wb_valid = wbv; wb_p = PREG_W'(wbp);
        set_commit(cmt);
        flush = fl;
        cycle();
    endtask

    task automatic rand_cycle(input int p_valid, input int p_ordy, input int p_commit,
                              input int p_wb, input int p_flush);
        in_valid  = chance(p_valid);
        in_sr1    = AREG_W'($urandom_range(0, ARCH_REGS - 1));
        in_sr2    = AREG_W'($urandom_range(0, ARCH_REGS - 1));
        in_dr     = AREG_W'($urandom_range(0, ARCH_REGS - 1));
        in_dr_wen = chance(80);
        out_ready = chance(p_ordy);
        wb_valid  = 0;
        wb_p      = '0;
        if (rob_q.size() > 0 && chance(p_wb)) begin
            int k;
            k = $urandom_range(0, rob_q.size() - 1);
            wb_valid = (rob_q[k].p != 0);
            wb_p     = PREG_W'(rob_q[k].p);
        end
        set_commit(chance(p_commit));
        flush = chance(p_flush);
        cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_dr_p"}, out_dr_p, 0);
        check({tag, "_out_old_dr_p"}, out_old_dr_p, 0);
        check({tag, "_out_sr1_p"}, out_sr1_p, 0);
        check({tag, "_out_rob_num"}, out_rob_num, 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cycle();
        check("in_ready_after_reset", in_ready, 1);
    endtask

    // Asynchronous reset landing mid-cycle, away from any clock edge.
    task automatic async_reset_mid();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_outputs_zero("async_reset");
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle();
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // First rename after reset: dr=5 gets the first free register.
        drive(1, 5, 0, 5, 1, 1, 0, 0, 0, 0);
        check("tp1_out_dr_p", out_dr_p, 32);
        check("tp1_out_old_dr_p", out_old_dr_p, 5);
        check("tp1_out_sr1_p", out_sr1_p, 5);
        check("tp1_s1_ready", out_s1_ready, 1);
        check("tp1_rob_num", out_rob_num, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Back-to-back dependency, without and with a same-cycle writeback.
        do_reset();
        drive(1, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
        check("tp2_sr1_p", out_sr1_p, 32);
        check("tp2_s1_not_ready", out_s1_ready, 0);
        drive(1, 3, 0, 0, 0, 1, 1, 32, 0, 0);
        check("tp2_s1_bypass", out_s1_ready, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Exhaust the free list, then recycle old mapping 7 through commit.
        do_reset();
        drive(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) drive(1, 0, 0, i, 1, 1, 0, 0, 0, 0);
        check("tp3_in_ready_empty", in_ready, 0);
        drive(1, 0, 0, 9, 1, 1, 0, 0, 1, 0);
        check("tp3_in_ready_back", in_ready, 1);
        drive(1, 0, 0, 10, 1, 1, 0, 0, 0, 0);
        check("tp3_recycled_dr_p", out_dr_p, 7);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Output stall for three cycles.
        do_reset();
        drive(1, 1, 2, 4, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
            check("tp4_stall_dr_p", out_dr_p, 32);
        end
        drive(1, 0, 0, 6, 1, 1, 0, 0, 0, 0);
        check("tp4_next_dr_p", out_dr_p, 33);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Flush after committing only the first of two renames.
        do_reset();
        drive(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        drive(1, 1, 2, 4, 1, 1, 0, 0, 0, 0);
        check("tp5_rat1", out_sr1_p, 32);
        check("tp5_rat2", out_sr2_p, 2);
        check("tp5_realloc", out_dr_p, 33);
        check("tp5_rob_num", out_rob_num, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Asynchronous reset while an instruction sits in the output register.
        do_reset();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        check("tp6_pre_out_valid", out_valid, 1);
        async_reset_mid();
        drive(1, 9, 17, 0, 0, 1, 0, 0, 0, 0);
        check("tp6_identity_sr1", out_sr1_p, 9);
        check("tp6_identity_sr2", out_sr2_p, 17);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Randomised phases: mixed traffic, no commits, heavy back-pressure.
        for (int i = 0; i < 2000; i++) rand_cycle(70, 70, 40, 30, 2);
        for (int i = 0; i < 400; i++)  rand_cycle(90, 90, 0, 20, 0);
        for (int i = 0; i < 300; i++)  rand_cycle(80, 20, 30, 30, 1);
        async_reset_mid();
        for (int i = 0; i < 1500; i++) rand_cycle(75, 60, 45, 40, 3);

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
